pkt_hdr_strip_align: RTL and testbench
======================================

# pkt_hdr_strip_align

Parametrised header-strip and payload-align stage for the packet datapath. Removes a per-packet header of 0 to 2^HW-1 bytes from an Avalon-ST style flit stream and re-packs the remaining payload so that payload byte 0 lands in the most-significant byte of the first output flit. Unlike the previous generation, it supports:
- full ready/valid backpressure;
- configurable bus width;
- dropping packets whose header consumes the whole packet, with a drop counter.

It sits between the packet parser and the payload matchers.

## Interface
Parameters:
- DW, 512: data width in bits; multiple of 8; B = DW/8 bytes per flit.
- HW, 9: header-length field width (bytes).
- EW, $clog2(DW/8): empty field width (derived; do not override).
- CW, 32: drop-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_pkt_valid  in  1  input flit valid
- in_pkt_ready  out  1  input flit accepted when valid & ready
- in_pkt_sop  in  1  first flit of packet
- in_pkt_eop  in  1  last flit of packet
- in_pkt_data  in  DW  flit data; byte 0 = data[DW-1:DW-8]
- in_pkt_empty  in  EW  unused bytes in the eop flit (LSB end)
- in_pkt_hdr  in  HW  header length in bytes; sampled only on an accepted sop flit
- out_pkt_valid  out  1  output flit valid
- out_pkt_ready  in  1  downstream ready
- out_pkt_sop  out  1  first payload flit
- out_pkt_eop  out  1  last payload flit
- out_pkt_data  out  DW  aligned payload
- out_pkt_empty  out  EW  unused bytes in the out eop flit; 0 when not eop
- drop_cnt  out  CW  packets dropped with an empty payload; saturating

## Operation
Header split, latched at the sop flit: k = hdr >> EW (flits to skip) and o = hdr & (B-1) (byte offset).

Output flit n is formed from:
- bytes [o..B-1] of input flit k+n, followed by
- bytes [0..o-1] of input flit k+n+1.

When o = 0, flits pass through unchanged.

State machine, states IDLE, SKIP, ALIGN, FLUSH:
- **IDLE**: wait for an accepted sop.
  - If k > 0, go to SKIP.
  - Otherwise, process the flit as the first payload flit.
- **SKIP**: count accepted flits until flit k, which is the first payload flit.
  - eop before flit k: drop the packet, increment drop_cnt, go to IDLE.
- **First payload flit** (v = B - empty valid bytes):
  - If eop and v <= o: drop (no output), increment drop_cnt.
  - If eop and v > o: emit a single flit with sop=eop=1, empty = o + e.
  - Otherwise: store its B - o residual bytes in a holding register and go to ALIGN. With o = 0, it is emitted directly instead.
- **ALIGN**: each accepted flit merges with the residual and emits one full flit.
  - On eop with empty e: if o + e >= B, emit the final flit with eop and empty = o + e - B, then go to IDLE.
  - Else emit a full flit, go to FLUSH, and hold the residual.
- **FLUSH**: emit the residual flit with eop and empty = o + e, then go to IDLE. in_pkt_ready = 0 during FLUSH.

Additional rules:
- sop is asserted on exactly the first emitted flit of each packet.
- All sums use EW+1 bits.
- in_pkt_hdr is ignored on non-sop flits.
- A sop arriving outside IDLE is a protocol error. No recovery is specified; the bench must not drive it.

## Timing
- Output is a single register stage.
- in_pkt_ready = (state != FLUSH) & (!out_pkt_valid | out_pkt_ready).
- out_* are stable while out_pkt_valid & !out_pkt_ready.
- Latency from the accepted input flit that completes an output flit to out_pkt_valid is 1 cycle.
- Throughput is 1 flit/cycle, except for one FLUSH cycle per packet when o + e < B and the packet spans at least two payload flits.
- Back-to-back packets need no idle cycle, apart from FLUSH.
- Dropped packets produce no output and never deassert in_pkt_ready.
- drop_cnt updates 1 cycle after the dropping flit is accepted.

Reset:
- state = IDLE; holding register cleared.
- out_pkt_valid/sop/eop = 0, out_pkt_data = 0, out_pkt_empty = 0, drop_cnt = 0.
- Reset mid-packet discards the packet. The next sop after reset is processed normally.

## Structure
- pkt_align_pkg holds the state enum typedef and the byte-width constant function.
- One sub-module: byte_funnel_shift #(DW). It is combinational: {hi, lo} and offset o give the B bytes starting at byte o of hi. It is used for both the ALIGN and FLUSH paths.

## Test plan
All scenarios use DW=512 (B=64).
- hdr=42, 150-byte packet (3 flits, empty=42) -> 2 output flits: full with sop, then eop with empty=20; 108 bytes matching input bytes 42..149.
- hdr=0, 100-byte packet -> 2 flits identical to input, second empty=28, latency 1 cycle.
- hdr=130 (k=2, o=2), 200-byte packet (empty=56) -> first 2 flits skipped; output full+sop, then FLUSH flit eop with empty=58 (6 bytes); in_pkt_ready low 1 cycle.
- hdr=80, 60-byte single flit; then hdr=60, 60-byte single flit -> both dropped, drop_cnt=2, no out_pkt_valid, in_pkt_ready constantly 1.
- Scenario 1 with out_pkt_ready random 50% plus back-to-back packets -> byte-identical output, no loss/duplication, out_* stable during stall.
- rst asserted during ALIGN of a 3-flit packet -> next cycle out_pkt_valid=0, drop_cnt=0; the following packet (hdr=10, 64 bytes) yields one flit eop with empty=10.

Source files
------------

// File: rtl/pkt_align_pkg.sv
// Shared state encoding and width helpers for the header-strip / payload-align stage.
package pkt_align_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SKIP  = 2'd1;
  localparam state_t ALIGN = 2'd2;
  localparam state_t FLUSH = 2'd3;

  function automatic int flit_bytes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/byte_funnel_shift.sv
// Combinational byte funnel: returns the B bytes of {hi, lo} starting at byte off of hi.
// Byte 0 is the most-significant byte of hi.
module byte_funnel_shift #(
  parameter int DW = 512,
  parameter int EW = $clog2(DW / 8)
) (
  input  logic [DW-1:0] hi,
  input  logic [DW-1:0] lo,
  input  logic [EW-1:0] off,
  output logic [DW-1:0] dout
);

  assign dout = DW'(({hi, lo} << {off, 3'b000}) >> DW);

endmodule

// File: rtl/pkt_hdr_strip_align.sv
// Strips a per-packet header of hdr bytes and re-packs the payload so payload byte 0
// lands in the MSB of the first output flit; packets with no payload are dropped and counted.
module pkt_hdr_strip_align
  import pkt_align_pkg::*;
#(
  parameter int DW = 512,
  parameter int HW = 9,
  parameter int EW = $clog2(DW / 8),
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_pkt_valid,
  output logic          in_pkt_ready,
  input  logic          in_pkt_sop,
  input  logic          in_pkt_eop,
  input  logic [DW-1:0] in_pkt_data,
  input  logic [EW-1:0] in_pkt_empty,
  input  logic [HW-1:0] in_pkt_hdr,
  output logic          out_pkt_valid,
  input  logic          out_pkt_ready,
  output logic          out_pkt_sop,
  output logic          out_pkt_eop,
  output logic [DW-1:0] out_pkt_data,
  output logic [EW-1:0] out_pkt_empty,
  output logic [CW-1:0] drop_cnt
);

  localparam int B  = flit_bytes(DW);
  localparam int KW = HW - EW;
  localparam logic [EW:0] B_EXT = (EW + 1)'(B);

  state_t        state, state_nxt;
  logic [KW-1:0] skip_cnt, skip_cnt_nxt;
  logic [EW-1:0] off_reg, off_nxt;
  logic [EW-1:0] tail_empty, tail_empty_nxt;
  logic          need_sop, need_sop_nxt;
  logic [DW-1:0] resid, resid_nxt;

  logic          out_free, accept, first_flit, drop, merge;
  logic          emit, emit_sop, emit_eop;
  logic [EW-1:0] emit_empty;
  logic [KW-1:0] hdr_k;
  logic [EW-1:0] hdr_o, cur_o;
  logic [EW:0]   in_v, o_plus_e, o_plus_e_wrap;
  logic [DW-1:0] fs_hi, fs_lo, fs_out;

  assign out_free     = !out_pkt_valid || out_pkt_ready;
  assign in_pkt_ready = (state != FLUSH) && out_free;
  assign accept       = in_pkt_valid && in_pkt_ready;

  assign hdr_k = in_pkt_hdr[HW-1:EW];
  assign hdr_o = in_pkt_hdr[EW-1:0];
  // The offset is only live on the hdr bus during the sop flit; later it comes from off_reg.
  assign cur_o = (state == IDLE) ? hdr_o : off_reg;

  assign in_v          = B_EXT - {1'b0, in_pkt_empty};
  assign o_plus_e      = {1'b0, cur_o} + {1'b0, in_pkt_empty};
  assign o_plus_e_wrap = o_plus_e - B_EXT;

  assign merge = (state == ALIGN) && (off_reg != '0);
  assign fs_hi = (merge || state == FLUSH) ? resid : in_pkt_data;
  assign fs_lo = merge ? in_pkt_data : '0;

  byte_funnel_shift #(.DW(DW), .EW(EW)) u_funnel (
    .hi   (fs_hi),
    .lo   (fs_lo),
    .off  (cur_o),
    .dout (fs_out)
  );

  always_comb begin
    state_nxt      = state;
    skip_cnt_nxt   = skip_cnt;
    off_nxt        = off_reg;
    tail_empty_nxt = tail_empty;
    need_sop_nxt   = need_sop;
    resid_nxt      = resid;
    first_flit     = 1'b0;
    drop           = 1'b0;
    emit           = 1'b0;
    emit_sop       = 1'b0;
    emit_eop       = 1'b0;
    emit_empty     = '0;

    case (state)
      IDLE: begin
        if (accept && in_pkt_sop) begin
          off_nxt = hdr_o;
          if (hdr_k != '0) begin
            if (in_pkt_eop) begin
              drop = 1'b1;
            end else begin
              skip_cnt_nxt = hdr_k - KW'(1);
              state_nxt    = SKIP;
            end
          end else begin
            first_flit = 1'b1;
          end
        end
      end
      SKIP: begin
        if (accept) begin
          if (skip_cnt == '0) begin
            first_flit = 1'b1;
          end else if (in_pkt_eop) begin
            drop      = 1'b1;
            state_nxt = IDLE;
          end else begin
            skip_cnt_nxt = skip_cnt - KW'(1);
          end
        end
      end
      ALIGN: begin
        if (accept) begin
          emit         = 1'b1;
          emit_sop     = need_sop;
          need_sop_nxt = 1'b0;
          resid_nxt    = in_pkt_data;
          if (in_pkt_eop) begin
            if (off_reg == '0) begin
              emit_eop   = 1'b1;
              emit_empty = in_pkt_empty;
              state_nxt  = IDLE;
            end else if (o_plus_e >= B_EXT) begin
              emit_eop   = 1'b1;
              emit_empty = o_plus_e_wrap[EW-1:0];
              state_nxt  = IDLE;
            end else begin
              tail_empty_nxt = o_plus_e[EW-1:0];
              state_nxt      = FLUSH;
            end
          end
        end
      end
      default: begin
        if (out_free) begin
          emit       = 1'b1;
          emit_eop   = 1'b1;
          emit_empty = tail_empty;
          state_nxt  = IDLE;
        end
      end
    endcase

    // First payload flit: a short eop drops, a real eop emits alone, otherwise start aligning.
    if (first_flit) begin
      if (in_pkt_eop) begin
        state_nxt = IDLE;
        if (in_v <= {1'b0, cur_o}) begin
          drop = 1'b1;
        end else begin
          emit       = 1'b1;
          emit_sop   = 1'b1;
          emit_eop   = 1'b1;
          emit_empty = o_plus_e[EW-1:0];
        end
      end else if (cur_o == '0) begin
        emit         = 1'b1;
        emit_sop     = 1'b1;
        need_sop_nxt = 1'b0;
        state_nxt    = ALIGN;
      end else begin
        resid_nxt    = in_pkt_data;
        need_sop_nxt = 1'b1;
        state_nxt    = ALIGN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      skip_cnt      <= '0;
      off_reg       <= '0;
      tail_empty    <= '0;
      need_sop      <= 1'b0;
      resid         <= '0;
      out_pkt_valid <= 1'b0;
      out_pkt_sop   <= 1'b0;
      out_pkt_eop   <= 1'b0;
      out_pkt_data  <= '0;
      out_pkt_empty <= '0;
      drop_cnt      <= '0;
    end else begin
      state      <= state_nxt;
      skip_cnt   <= skip_cnt_nxt;
      off_reg    <= off_nxt;
      tail_empty <= tail_empty_nxt;
      need_sop   <= need_sop_nxt;
      resid      <= resid_nxt;
      if (out_free) begin
        out_pkt_valid <= emit;
        if (emit) begin
          out_pkt_sop   <= emit_sop;
          out_pkt_eop   <= emit_eop;
          out_pkt_data  <= fs_out;
          out_pkt_empty <= emit_empty;
        end
      end
      if (drop && drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pkt_hdr_strip_align.sv
// Scoreboard bench for pkt_hdr_strip_align: a byte-level model pushes expected output flits
// as packets are driven, and a negedge monitor pops and compares them on each output handshake.
module tb_pkt_hdr_strip_align;

  localparam int DW = 512;
  localparam int HW = 9;
  localparam int EW = 6;
  localparam int CW = 32;
  localparam int B  = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_pkt_valid, in_pkt_ready, in_pkt_sop, in_pkt_eop;
  logic [DW-1:0] in_pkt_data;
  logic [EW-1:0] in_pkt_empty;
  logic [HW-1:0] in_pkt_hdr;
  logic          out_pkt_valid, out_pkt_ready, out_pkt_sop, out_pkt_eop;
  logic [DW-1:0] out_pkt_data;
  logic [EW-1:0] out_pkt_empty;
  logic [CW-1:0] drop_cnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   out_count = 0;
  int   ready_low_cnt = 0;
  int   model_drops = 0;
  int   sop_acc_cyc = -1;
  int   first_sop_cyc = -1;
  bit   rand_ready = 1'b0;

  logic          stall_prev = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_sop, held_eop;
  logic [EW-1:0] held_empty;

  pkt_hdr_strip_align #(.DW(DW), .HW(HW), .EW(EW), .CW(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_pkt_valid  (in_pkt_valid),
    .in_pkt_ready  (in_pkt_ready),
    .in_pkt_sop    (in_pkt_sop),
    .in_pkt_eop    (in_pkt_eop),
    .in_pkt_data   (in_pkt_data),
    .in_pkt_empty  (in_pkt_empty),
    .in_pkt_hdr    (in_pkt_hdr),
    .out_pkt_valid (out_pkt_valid),
    .out_pkt_ready (out_pkt_ready),
    .out_pkt_sop   (out_pkt_sop),
    .out_pkt_eop   (out_pkt_eop),
    .out_pkt_data  (out_pkt_data),
    .out_pkt_empty (out_pkt_empty),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_pkt_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: scoreboard pop on every output handshake, plus output stability while stalled.
  always @(negedge clk) begin
    exp_t          e;
    int            nb;
    logic [DW-1:0] mask;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if ({out_pkt_valid, out_pkt_sop, out_pkt_eop, out_pkt_empty, out_pkt_data} !==
            {1'b1, held_sop, held_eop, held_empty, held_data})
          $display("[TB] FAIL stall_stable: outputs changed while stalled (got valid=%0b sop=%0b eop=%0b empty=%0d, required valid=1 sop=%0b eop=%0b empty=%0d)",
                   out_pkt_valid, out_pkt_sop, out_pkt_eop, out_pkt_empty, held_sop, held_eop, held_empty);
        else passes++;
      end
      if (in_pkt_ready !== 1'b1) ready_low_cnt++;
      if (out_pkt_valid === 1'b1 && out_pkt_ready === 1'b1) begin
        out_count++;
        checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL unexpected_flit: got output flit sop=%0b eop=%0b, required no output", out_pkt_sop, out_pkt_eop);
        end else begin
          e = exp_q.pop_front();
          nb = e.eop ? (B - int'(e.empty)) : B;
          mask = ~({DW{1'b1}} >> (8 * nb));
          if (out_pkt_sop !== e.sop || out_pkt_eop !== e.eop || out_pkt_empty !== e.empty ||
              (out_pkt_data & mask) !== (e.data & mask))
            $display("[TB] FAIL out_flit: got sop=%0b eop=%0b empty=%0d data=%h, required sop=%0b eop=%0b empty=%0d data=%h",
                     out_pkt_sop, out_pkt_eop, out_pkt_empty, out_pkt_data & mask, e.sop, e.eop, e.empty, e.data & mask);
          else passes++;
        end
        if (out_pkt_sop === 1'b1 && first_sop_cyc < 0) first_sop_cyc = cyc;
      end
      stall_prev = (out_pkt_valid === 1'b1) && (out_pkt_ready !== 1'b1);
      held_data  = out_pkt_data;
      held_sop   = out_pkt_sop;
      held_eop   = out_pkt_eop;
      held_empty = out_pkt_empty;
    end
  end

  // Drives one packet (optionally only its first max_flits flits) and pushes the model's output.
  task automatic send_packet(input int hdr, input int len, input bit push_exp, input int max_flits);
    logic [7:0]    pkt[$];
    logic [DW-1:0] flit;
    exp_t          e;
    int            nfl, plen, nout, f, budget, idx;
    bit            acc;
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    nfl  = (len + B - 1) / B;
    plen = len - hdr;
    if (push_exp) begin
      if (plen <= 0) begin
        model_drops++;
      end else begin
        nout = (plen + B - 1) / B;
        for (int n = 0; n < nout; n++) begin
          e.data = '0;
          for (int j = 0; j < B; j++) begin
            idx = n * B + j;
            if (idx < plen) e.data[DW-1-8*j -: 8] = pkt[hdr + idx];
          end
          e.sop   = (n == 0);
          e.eop   = (n == nout - 1);
          e.empty = e.eop ? EW'(nout * B - plen) : '0;
          exp_q.push_back(e);
        end
      end
    end
    f = 0;
    budget = 0;
    while (f < nfl && f < max_flits) begin
      flit = '0;
      for (int j = 0; j < B; j++) begin
        idx = f * B + j;
        if (idx < len) flit[DW-1-8*j -: 8] = pkt[idx];
      end
      in_pkt_valid = 1'b1;
      in_pkt_sop   = (f == 0);
      in_pkt_eop   = (f == nfl - 1);
      in_pkt_data  = flit;
      in_pkt_empty = (f == nfl - 1) ? EW'(nfl * B - len) : '0;
      in_pkt_hdr   = (f == 0) ? HW'(hdr) : HW'($urandom);
      @(negedge clk);
      acc = (in_pkt_ready === 1'b1);
      @(posedge clk);
      #1;
      if (acc) begin
        if (f == 0) sop_acc_cyc = cyc;
        f++;
      end else if (++budget > 2000) begin
        checks++;
        $display("[TB] FAIL in_accept_timeout: got in_pkt_ready low for %0d cycles, required acceptance", budget);
        break;
      end
    end
    in_pkt_valid = 1'b0;
    in_pkt_sop   = 1'b0;
    in_pkt_eop   = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_pkt_valid = 1'b0;
    out_pkt_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_pkt_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b required 0", out_pkt_valid);
    else passes++;
    checks++;
    if ({out_pkt_sop, out_pkt_eop} !== 2'b00) $display("[TB] FAIL reset_sop_eop: got %b required 00", {out_pkt_sop, out_pkt_eop});
    else passes++;
    checks++;
    if (out_pkt_data !== '0 || out_pkt_empty !== '0)
      $display("[TB] FAIL reset_data_empty: got data=%h empty=%0d required 0", out_pkt_data, out_pkt_empty);
    else passes++;
    checks++;
    if (drop_cnt !== '0) $display("[TB] FAIL reset_drop_cnt: got %0d required 0", drop_cnt);
    else passes++;
    checks++;
    if (in_pkt_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b required 1", in_pkt_ready);
    else passes++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_drops = 0;
  endtask

  task automatic test_strip_42();
    int start;
    bit ok;
    start = out_count;
    send_packet(42, 150, 1'b1, 1000);
    wait_drain(ok);
    checks++;
    if (!ok) $display("[TB] FAIL strip42_drain: got %0d flits pending required 0", exp_q.size());
    else passes++;
    checks++;
    if (out_count - start !== 2) $display("[TB] FAIL strip42_count: got %0d flits required 2", out_count - start);
    else passes++;
  endtask

  task automatic test_passthrough();
    int start;
    bit ok;
    start = out_count;
    first_sop_cyc = -1;
    send_packet(0, 100, 1'b1, 1000);
    wait_drain(ok);
    checks++;
    if (!ok || out_count - start !== 2)
      $display("[TB] FAIL passthru_count: got %0d flits required 2", out_count - start);
    else passes++;
    checks++;
    if (first_sop_cyc !== sop_acc_cyc)
      $display("[TB] FAIL passthru_latency: got out sop at cycle %0d required cycle %0d", first_sop_cyc, sop_acc_cyc);
    else passes++;
  endtask

  task automatic test_skip_flush();
    int start;
    bit ok;
    start = out_count;
    ready_low_cnt = 0;
    send_packet(130, 200, 1'b1, 1000);
    wait_drain(ok);
    checks++;
    if (!ok || out_count - start !== 2)
      $display("[TB] FAIL skip_flush_count: got %0d flits required 2", out_count - start);
    else passes++;
    checks++;
    if (ready_low_cnt !== 1) $display("[TB] FAIL skip_flush_ready_low: got %0d cycles required 1", ready_low_cnt);
    else passes++;
  endtask

  task automatic test_drop();
    int start;
    start = out_count;
    ready_low_cnt = 0;
    send_packet(80, 60, 1'b1, 1000);
    send_packet(60, 60, 1'b1, 1000);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (drop_cnt !== CW'(2)) $display("[TB] FAIL drop_cnt: got %0d required 2", drop_cnt);
    else passes++;
    checks++;
    if (out_count - start !== 0) $display("[TB] FAIL drop_no_output: got %0d flits required 0", out_count - start);
    else passes++;
    checks++;
    if (ready_low_cnt !== 0) $display("[TB] FAIL drop_ready: got in_pkt_ready low %0d cycles required 0", ready_low_cnt);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int hdrs[10] = '{42, 0, 130, 80, 5, 63, 64, 10, 0, 127};
    int lens[10] = '{150, 100, 200, 60, 64, 130, 128, 300, 64, 129};
    bit ok;
    rand_ready = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 10; i++) send_packet(hdrs[i], lens[i], 1'b1, 1000);
    send_packet(42, 150, 1'b1, 1000);
    rand_ready = 1'b0;
    out_pkt_ready = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok) $display("[TB] FAIL b2b_drain: got %0d flits pending required 0", exp_q.size());
    else passes++;
    checks++;
    if (drop_cnt !== CW'(model_drops)) $display("[TB] FAIL b2b_drop_cnt: got %0d required %0d", drop_cnt, model_drops);
    else passes++;
  endtask

  task automatic test_reset_mid_packet();
    int start;
    bit ok;
    out_pkt_ready = 1'b0;
    send_packet(42, 150, 1'b0, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_drops = 0;
    @(negedge clk);
    checks++;
    if (out_pkt_valid !== 1'b0) $display("[TB] FAIL midreset_valid: got %b required 0", out_pkt_valid);
    else passes++;
    checks++;
    if (drop_cnt !== '0) $display("[TB] FAIL midreset_drop_cnt: got %0d required 0", drop_cnt);
    else passes++;
    @(posedge clk);
    #1;
    out_pkt_ready = 1'b1;
    start = out_count;
    send_packet(10, 64, 1'b1, 1000);
    wait_drain(ok);
    checks++;
    if (!ok || out_count - start !== 1)
      $display("[TB] FAIL midreset_next_pkt: got %0d flits required 1", out_count - start);
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    in_pkt_valid = 1'b0;
    in_pkt_sop = 1'b0;
    in_pkt_eop = 1'b0;
    in_pkt_data = '0;
    in_pkt_empty = '0;
    in_pkt_hdr = '0;
    out_pkt_ready = 1'b1;
    test_reset();
    test_strip_42();
    test_passthrough();
    test_skip_flush();
    test_drop();
    test_back_to_back();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
